monitoreo: RTL and testbench

Temperature supervision block for a climate-control path. It samples a signed sensor reading in tenths of a degree Celsius once per clock and classifies it as normal, cold, hot or sensor fault. Cold and hot conditions must persist before they are acted on, so short transients are filtered out. It drives a heater request, a fan request, an alert flag and an encoded state for status reporting.

---
 rtl/monitoreo_if.sv | 32 +++
 rtl/monitoreo.sv | 178 +++++++++++++++++
 tb/tb_monitoreo.sv | 113 +++++++++++
 3 files changed

// File: rtl/monitoreo_if.sv
// -----------------------------------------------------------------------------
// monitoreo_if
// Groups the sensor sample and the supervision outputs of the monitoreo block.
//   temp_entrada  : signed 11-bit reading, 0.1 degC per LSB (master -> slave)
//   alerta        : any abnormal condition (COLD, HOT or FAULT)
//   calefactor    : heater request (COLD only)
//   ventilador    : fan request (HOT only)
//   estado_actual : encoded state, NORMAL=00 FRIO=01 CALOR=10 FALLA=11
// -----------------------------------------------------------------------------
interface monitoreo_if;
  logic signed [10:0] temp_entrada;
  logic               alerta;
  logic               calefactor;
  logic               ventilador;
  logic [1:0]         estado_actual;

  modport master (
    output temp_entrada,
    input  alerta,
    input  calefactor,
    input  ventilador,
    input  estado_actual
  );

  modport slave (
    input  temp_entrada,
    output alerta,
    output calefactor,
    output ventilador,
    output estado_actual
  );
endinterface

// File: rtl/monitoreo.sv
// -----------------------------------------------------------------------------
// monitoreo
// Temperature supervision: classifies each sample as normal / cold / hot /
// invalid, filters cold and hot through a persistence counter and drives the
// heater, fan, alert and encoded state from a Moore state machine.
// Ports:
//   clk    : system clock, rising edge
//   arst_n : synchronous reset, ACTIVE HIGH despite the historical name
//   bus    : monitoreo_if.slave (temp_entrada in, status outputs out)
// All outputs are registered; there is no combinational path from the sample.
// -----------------------------------------------------------------------------
module monitoreo #(
  parameter int UMBRAL_FRIO         = 180,
  parameter int UMBRAL_CALOR        = 280,
  parameter int TEMP_MIN            = -400,
  parameter int TEMP_MAX            = 1000,
  parameter int CICLOS_PERSISTENCIA = 5
) (
  input  logic        clk,
  input  logic        arst_n,
  monitoreo_if.slave  bus
);

  localparam int CW = $clog2(CICLOS_PERSISTENCIA + 1);
  localparam logic [CW-1:0]      P_N     = CW'(CICLOS_PERSISTENCIA);
  localparam logic [CW-1:0]      P_UNO   = CW'(1);
  localparam logic signed [10:0] P_FRIO  = 11'(UMBRAL_FRIO);
  localparam logic signed [10:0] P_CALOR = 11'(UMBRAL_CALOR);
  localparam logic signed [10:0] P_TMIN  = 11'(TEMP_MIN);
  localparam logic signed [10:0] P_TMAX  = 11'(TEMP_MAX);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIO   = 2'b01,
    CALOR  = 2'b10,
    FALLA  = 2'b11
  } estado_t;

  typedef enum logic [1:0] {
    CL_NORMAL   = 2'b00,
    CL_FRIO     = 2'b01,
    CL_CALOR    = 2'b10,
    CL_INVALIDA = 2'b11
  } clase_t;

  logic signed [10:0] w_temp;
  clase_t             w_clase;
  clase_t             r_clase_prev;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic [CW-1:0]      r_ok;
  logic [CW-1:0]      w_ok_next;
  estado_t            r_estado;
  estado_t            w_estado_next;
  logic               r_alerta;
  logic               r_calefactor;
  logic               r_ventilador;

  assign w_temp = bus.temp_entrada;

  // Sample classification, invalid range has priority over cold/hot
  always_comb begin
    w_clase = CL_NORMAL;
    if ((w_temp < P_TMIN) || (w_temp > P_TMAX)) begin
      w_clase = CL_INVALIDA;
    end else if (w_temp < P_FRIO) begin
      w_clase = CL_FRIO;
    end else if (w_temp > P_CALOR) begin
      w_clase = CL_CALOR;
    end else begin
      w_clase = CL_NORMAL;
    end
  end

  // Next values of the class-persistence counter and the valid-run counter.
  // The class counter treats 0 (just out of reset) as "no history" so the
  // first sample always counts as 1. The valid-run counter drives the exit
  // from FALLA, where any valid class counts regardless of cold/hot swings.
  always_comb begin
    w_cnt_next = P_UNO;
    w_ok_next  = '0;
    if ((w_clase == r_clase_prev) && (r_cnt != '0)) begin
      if (r_cnt >= P_N) begin
        w_cnt_next = r_cnt;
      end else begin
        w_cnt_next = r_cnt + P_UNO;
      end
    end else begin
      w_cnt_next = P_UNO;
    end
    if (w_clase == CL_INVALIDA) begin
      w_ok_next = '0;
    end else if (r_ok >= P_N) begin
      w_ok_next = r_ok;
    end else begin
      w_ok_next = r_ok + P_UNO;
    end
  end

  // Next-state logic
  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      NORMAL: begin
        if (w_clase == CL_INVALIDA) begin
          w_estado_next = FALLA;
        end else if ((w_clase == CL_FRIO) && (w_cnt_next >= P_N)) begin
          w_estado_next = FRIO;
        end else if ((w_clase == CL_CALOR) && (w_cnt_next >= P_N)) begin
          w_estado_next = CALOR;
        end else begin
          w_estado_next = NORMAL;
        end
      end
      FRIO: begin
        if (w_clase == CL_INVALIDA) begin
          w_estado_next = FALLA;
        end else if (w_clase == CL_FRIO) begin
          w_estado_next = FRIO;
        end else begin
          w_estado_next = NORMAL;
        end
      end
      CALOR: begin
        if (w_clase == CL_INVALIDA) begin
          w_estado_next = FALLA;
        end else if (w_clase == CL_CALOR) begin
          w_estado_next = CALOR;
        end else begin
          w_estado_next = NORMAL;
        end
      end
      FALLA: begin
        if (w_ok_next >= P_N) begin
          w_estado_next = NORMAL;
        end else begin
          w_estado_next = FALLA;
        end
      end
      default: w_estado_next = NORMAL;
    endcase
  end

  // State register and sample history
  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_estado     <= NORMAL;
      r_clase_prev <= CL_NORMAL;
      r_cnt        <= '0;
      r_ok         <= '0;
    end else begin
      r_estado     <= w_estado_next;
      r_clase_prev <= w_clase;
      r_cnt        <= w_cnt_next;
      r_ok         <= w_ok_next;
    end
  end

  // Registered output decode of the state being entered, so outputs change
  // on the same edge as the state register
  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_alerta     <= 1'b0;
      r_calefactor <= 1'b0;
      r_ventilador <= 1'b0;
    end else begin
      r_alerta     <= (w_estado_next != NORMAL);
      r_calefactor <= (w_estado_next == FRIO);
      r_ventilador <= (w_estado_next == CALOR);
    end
  end

  assign bus.alerta        = r_alerta;
  assign bus.calefactor    = r_calefactor;
  assign bus.ventilador    = r_ventilador;
  assign bus.estado_actual = r_estado;

endmodule

// File: tb/tb_monitoreo.sv
// -----------------------------------------------------------------------------
// tb_monitoreo
// Directed bench for monitoreo with default parameters. Each check compares the
// packed status {estado_actual, alerta, calefactor, ventilador} with a
// hand-computed constant, sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_monitoreo;
  logic clk;
  logic arst_n;
  int   errors;
  int   checks;

  localparam logic [4:0] S_NORMAL = 5'b00_000;
  localparam logic [4:0] S_FRIO   = 5'b01_110;
  localparam logic [4:0] S_CALOR  = 5'b10_101;
  localparam logic [4:0] S_FALLA  = 5'b11_100;

  monitoreo_if bus ();

  monitoreo dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one sample for one clock edge, then settle past the edge
  task automatic paso(input logic signed [10:0] t);
    bus.temp_entrada = t;
    @(posedge clk);
    #1;
  endtask

  task automatic pasos(input logic signed [10:0] t, input int n);
    for (int i = 0; i < n; i++) paso(t);
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.estado_actual, bus.alerta, bus.calefactor, bus.ventilador};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    arst_n = 1'b1;
    bus.temp_entrada = 11'sd220;
    pasos(11'sd220, 2);
    chk("reset", S_NORMAL);
    arst_n = 1'b0;

    pasos(11'sd220, 5);            chk("normal_220", S_NORMAL);

    pasos(11'sd150, 4);            chk("cold_4th_edge", S_NORMAL);
    paso(11'sd150);                chk("cold_5th_edge", S_FRIO);
    pasos(11'sd150, 5);            chk("cold_hold", S_FRIO);
    paso(11'sd200);                chk("cold_exit", S_NORMAL);

    paso(11'sd300);                chk("transient_1", S_NORMAL);
    paso(11'sd300);                chk("transient_2", S_NORMAL);
    paso(11'sd220);                chk("transient_end", S_NORMAL);

    pasos(11'sd350, 4);            chk("hot_4th_edge", S_NORMAL);
    paso(11'sd350);                chk("hot_5th_edge", S_CALOR);
    pasos(11'sd350, 5);            chk("hot_hold", S_CALOR);

    // Hot -> cold crossing: the cold run starts counting on the exit edge
    paso(11'sd150);                chk("hot_to_cold_exit", S_NORMAL);
    pasos(11'sd150, 3);            chk("cold_count_4", S_NORMAL);
    paso(11'sd150);                chk("cold_count_5", S_FRIO);

    paso(-11'sd500);               chk("fault_enter", S_FALLA);
    pasos(11'sd220, 4);            chk("fault_4_valid", S_FALLA);
    paso(11'sd220);                chk("fault_exit", S_NORMAL);

    // Fault exit counts any valid sample, even with class changes
    paso(11'sd1001);               chk("above_max_fault", S_FALLA);
    paso(11'sd150);
    paso(11'sd220);
    paso(11'sd350);
    paso(11'sd150);                chk("fault_mixed_4", S_FALLA);
    paso(11'sd220);                chk("fault_mixed_exit", S_NORMAL);

    pasos(11'sd180, 6);            chk("boundary_180", S_NORMAL);
    pasos(11'sd280, 6);            chk("boundary_280", S_NORMAL);
    pasos(-11'sd400, 5);           chk("min_is_valid_cold", S_FRIO);
    paso(11'sd1000);               chk("max_leaves_cold", S_NORMAL);
    pasos(11'sd1000, 4);           chk("max_is_valid_hot", S_CALOR);
    paso(-11'sd401);               chk("below_min_fault", S_FALLA);
    pasos(11'sd220, 5);            chk("recover", S_NORMAL);

    // Reset mid-count clears the counter
    pasos(11'sd150, 3);
    arst_n = 1'b1;
    paso(11'sd150);                chk("reset_midcount", S_NORMAL);
    arst_n = 1'b0;
    pasos(11'sd150, 4);            chk("after_reset_4", S_NORMAL);
    paso(11'sd150);                chk("after_reset_5", S_FRIO);
    arst_n = 1'b1;
    paso(11'sd150);                chk("reset_from_frio", S_NORMAL);
    arst_n = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
